// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto one single-port synchronous memory.
// Optional MEM_ARB_RR_EN selects round-robin contention; undefined gives fixed port-0 priority.
module mem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          busy_q, busy_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          pick1;

`ifdef MEM_ARB_RR_EN
  // 1 = port 1 wins the next contention; flips to the other port on every grant.
  logic          prio_q, prio_d;
  assign pick1 = req1 & (~req0 | prio_q);
`else
  assign pick1 = req1 & ~req0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    busy_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    prio_d     = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d    = ISSUE;
          mem_en_d   = 1'b1;
          mem_we_d   = pick1 ? we1 : we0;
          mem_addr_d = pick1 ? addr1 : addr0;
          mem_din_d  = pick1 ? wdata1 : wdata0;
          gnt0_d     = ~pick1;
          gnt1_d     = pick1;
          busy_d     = 1'b1;
`ifdef MEM_ARB_RR_EN
          prio_d     = ~pick1;
`endif
        end
      end
      ISSUE: begin
        // gnt1_q identifies the winner of the access the memory samples this cycle.
        state_d   = IDLE;
        rvalid0_d = ~mem_we_q & gnt0_q;
        rvalid1_d = ~mem_we_q & gnt1_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      busy_q     <= busy_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
`ifdef MEM_ARB_RR_EN
      prio_q     <= prio_d;
`endif
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign busy     = busy_q;
  assign mem_en   = mem_en_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign rdata    = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic on both ports against a cycle-schedule reference
// model with a shadow memory; arbitration follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int NW   = 1 << AW;
  localparam int MAXC = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, gnt0, rvalid0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata, mem_din, mem_dout;
  logic          busy, mem_en, mem_we;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, read-first, one-cycle read latency, no reset.
  logic [DW-1:0] tb_mem [0:NW-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_din;
      mem_dout <= tb_mem[mem_addr];
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  op_t q0[$];
  op_t q1[$];

  // Expected outputs per cycle index, filled in by the model when it schedules an access.
  logic          exp_gnt0 [MAXC];
  logic          exp_gnt1 [MAXC];
  logic          exp_en   [MAXC];
  logic          exp_we   [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  logic [DW-1:0] exp_din  [MAXC];
  logic          exp_rv0  [MAXC];
  logic          exp_rv1  [MAXC];
  logic [DW-1:0] exp_rdata[MAXC];
  logic [DW-1:0] shadow   [NW];

  int   cyc      = 0;
  int   free_cyc = 0;
  logic rr_prio  = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  function automatic op_t mk(input logic we, input int a, input int d);
    op_t o;
    o.we = we;
    o.a  = AW'(a);
    o.d  = DW'(d);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_exp(input int k);
    exp_gnt0[k] = 1'b0; exp_gnt1[k] = 1'b0; exp_en[k] = 1'b0; exp_we[k] = 1'b0;
    exp_rv0[k]  = 1'b0; exp_rv1[k]  = 1'b0;
  endtask

  // Accesses are granted the cycle after sampling; reads return data one cycle later;
  // the memory is busy for two cycles per access.
  task automatic model_sample(input logic rs, input logic v0, input op_t o0,
                              input logic v1, input op_t o1,
                              output logic g0, output logic g1);
    logic w1;
    op_t  o;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rs) begin
      clear_exp(cyc + 1);
      clear_exp(cyc + 2);
      free_cyc = cyc + 1;
      rr_prio  = 1'b0;
    end else if (cyc >= free_cyc && (v0 || v1)) begin
`ifdef MEM_ARB_RR_EN
      w1 = v1 && (!v0 || rr_prio);
`else
      w1 = v1 && !v0;
`endif
      rr_prio = !w1;
      o  = w1 ? o1 : o0;
      g0 = !w1;
      g1 = w1;
      exp_gnt0[cyc+1] = !w1;
      exp_gnt1[cyc+1] = w1;
      exp_en[cyc+1]   = 1'b1;
      exp_we[cyc+1]   = o.we;
      exp_addr[cyc+1] = o.a;
      exp_din[cyc+1]  = o.d;
      if (o.we) begin
        shadow[o.a] = o.d;
      end else begin
        exp_rv0[cyc+2]   = !w1;
        exp_rv1[cyc+2]   = w1;
        exp_rdata[cyc+2] = shadow[o.a];
      end
      free_cyc = cyc + 2;
    end
  endtask

  task automatic check_cycle();
    chk("gnt0", 32'(gnt0), 32'(exp_gnt0[cyc]));
    chk("gnt1", 32'(gnt1), 32'(exp_gnt1[cyc]));
    chk("busy", 32'(busy), 32'(exp_gnt0[cyc] | exp_gnt1[cyc]));
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv0[cyc]));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv1[cyc]));
    chk("mem_en", 32'(mem_en), 32'(exp_en[cyc]));
    chk("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
    if (exp_en[cyc]) begin
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
      chk("mem_din", 32'(mem_din), 32'(exp_din[cyc]));
    end
    if (exp_rv0[cyc] || exp_rv1[cyc]) chk("rdata", 32'(rdata), 32'(exp_rdata[cyc]));
  endtask

  task automatic step(input logic rs);
    logic v0, v1, g0, g1;
    op_t  o0, o1;
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    o0 = v0 ? q0[0] : op_t'($urandom);
    o1 = v1 ? q1[0] : op_t'($urandom);
    rst = rs;
    req0 = v0; we0 = o0.we; addr0 = o0.a; wdata0 = o0.d;
    req1 = v1; we1 = o1.we; addr1 = o1.a; wdata1 = o1.d;
    model_sample(rs, v0, o0, v1, o1, g0, g1);
    if (g0) void'(q0.pop_front());
    if (g1) void'(q1.pop_front());
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++) step(1'b0);
    chk("drain_left", 32'(q0.size() + q1.size()), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0);
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      clear_exp(k);
      exp_addr[k] = '0; exp_din[k] = '0; exp_rdata[k] = '0;
    end
    for (int a = 0; a < NW; a++) shadow[a] = '0;

    // Reset state.
    step(1'b1);
    step(1'b1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    step(1'b0);

    // T1: write then read back on port 0.
    q0.push_back(mk(1'b1, 3, 8'hAA));
    q0.push_back(mk(1'b0, 3, 0));
    drain();

    // T4: port 1 fills every address with its own value, port 0 reads all back.
    for (int a = NW - 1; a >= 0; a--) q1.push_back(mk(1'b1, a, a));
    drain();
    for (int a = 0; a < NW; a++) q0.push_back(mk(1'b0, a, 0));
    drain();

    // T2: simultaneous reads from both ports.
    q0.push_back(mk(1'b1, 0, 8'hAA));
    q1.push_back(mk(1'b1, 1, 8'h55));
    drain();
    q0.push_back(mk(1'b0, 0, 0));
    q1.push_back(mk(1'b0, 1, 0));
    drain();

    // T3: both ports stream writes.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, $urandom_range(0, NW - 1), $urandom_range(0, 255)));
      q1.push_back(mk(1'b1, $urandom_range(0, NW - 1), $urandom_range(0, 255)));
    end
    drain();

    // T5: reset lands during the issue of a port 0 read, then contention.
    q0.push_back(mk(1'b1, 7, 8'h3C));
    drain();
    q0.push_back(mk(1'b0, 5, 0));
    step(1'b0);
    step(1'b1);
    q0.push_back(mk(1'b1, 9, 8'h11));
    q1.push_back(mk(1'b1, 10, 8'h22));
    drain();

    // T6: a port 0 request present only during another port's issue cycle.
    q1.push_back(mk(1'b1, 12, 8'h99));
    step(1'b0);
    q0.push_back(mk(1'b0, 2, 0));
    step(1'b0);
    q0.delete();
    for (int i = 0; i < 3; i++) step(1'b0);

    // Random mixed traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0)
        q0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, NW - 1), $urandom_range(0, 255)));
      if (q1.size() < 3 && $urandom_range(0, 2) == 0)
        q1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, NW - 1), $urandom_range(0, 255)));
      step(1'($urandom_range(0, 63) == 0));
    end
    drain();

    // Final read-back of the whole memory through port 1.
    for (int a = 0; a < NW; a++) q1.push_back(mk(1'b0, a, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
